// File: rtl/ifu_idu_queue.sv
// IF/ID decoupling queue: DEPTH-entry in-order FIFO between fetch and decode,
// with valid/ready on both sides, flush, jump squash and bubble-filled outputs.
module ifu_idu_queue #(
  parameter int                INST_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 4,
  parameter logic [INST_W-1:0] BUBBLE_INST = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_addr,
  input  logic                       flush_i,
  input  logic                       jump_flag_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              full, empty, push, pop;
  logic [IW-1:0]     wr_idx, rd_idx;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count_o   = wr_ptr_q - rd_ptr_q;

  // A squashed beat still handshakes (in_ready high) but is never written.
  assign push = in_valid && !full && !flush_i && !jump_flag_i;
  assign pop  = !empty && out_ready && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (flush_i) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_idx] <= in_inst;
      addr_mem[wr_idx] <= in_addr;
    end
  end

  assign out_inst = out_valid ? inst_mem[rd_idx] : BUBBLE_INST;
  assign out_addr = out_valid ? addr_mem[rd_idx] : '0;

endmodule

// File: tb/tb_ifu_idu_queue.sv
// Self-checking bench for ifu_idu_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_ifu_idu_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        flush_i = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [2:0]  count_o;

  ent_t model[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifu_idu_queue #(
    .INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .flush_i(flush_i), .jump_flag_i(jump_flag_i), .count_o(count_o)
  );

  function automatic logic [31:0] exp_addr();
    return (model.size() != 0) ? model[0].addr : 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return (model.size() != 0) ? model[0].inst : BUBBLE;
  endfunction

  // Advance one clock edge, updating the reference model from the driven inputs.
  task automatic tick();
    bit take, drain;
    take  = in_valid && (model.size() < DEPTH) && !flush_i && !jump_flag_i;
    drain = (model.size() > 0) && out_ready && !flush_i;
    @(posedge clk);
    if (flush_i) begin
      model.delete();
    end else begin
      if (drain) void'(model.pop_front());
      if (take) model.push_back('{inst: in_inst, addr: in_addr});
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush_i = 0; jump_flag_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model.delete();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_vec++; if (out_inst !== BUBBLE) begin n_err++; $display("FAIL reset_out_inst got=%h exp=%h", out_inst, BUBBLE); end
    n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    $display("reset: out_valid=%0b count=%0d in_ready=%0b", out_valid, count_o, in_ready);
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_addr = 32'h8000_0000 + 32'(4 * i); in_inst = $urandom;
      tick();
      n_vec++; if (count_o !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, i + 1); end
      $display("fill: push addr=%h count=%0d", in_addr, count_o);
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready_full got=%0b exp=0", in_ready); end
    in_addr = 32'h8000_0010; in_inst = $urandom;
    tick();
    n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL fill_fifth_not_taken got=%0d exp=4", count_o); end
    n_vec++; if (out_addr !== 32'h8000_0000) begin n_err++; $display("FAIL fill_head_addr got=%h exp=80000000", out_addr); end
    n_vec++; if (out_inst !== exp_inst()) begin n_err++; $display("FAIL fill_head_inst got=%h exp=%h", out_inst, exp_inst()); end
    $display("fill: fifth beat offered, count=%0d head=%h", count_o, out_addr);
  endtask

  task automatic test_flush_full();
    in_valid = 1; flush_i = 1; in_addr = 32'hDEAD_0000; in_inst = $urandom;
    tick();
    flush_i = 0; in_valid = 0;
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
    n_vec++; if (out_inst !== BUBBLE) begin n_err++; $display("FAIL flush_bubble got=%h exp=%h", out_inst, BUBBLE); end
    $display("flush: count=%0d out_valid=%0b", count_o, out_valid);
    in_valid = 1; in_addr = 32'h9000_0000; in_inst = $urandom;
    tick();
    in_valid = 0;
    n_vec++; if (out_addr !== 32'h9000_0000) begin n_err++; $display("FAIL flush_next_head got=%h exp=90000000", out_addr); end
    n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL flush_next_count got=%0d exp=1", count_o); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drain_empty got=%0b exp=0", out_valid); end
    $display("flush: post-flush push seen alone, drained");
  endtask

  task automatic test_streaming();
    logic [31:0] base;
    base = 32'h0000_1000;
    idle_inputs();
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      in_addr = base + 32'(4 * k); in_inst = $urandom;
      tick();
      n_vec++; if (out_addr !== base + 32'(4 * k)) begin n_err++; $display("FAIL stream_order[%0d] got=%h exp=%h", k, out_addr, base + 32'(4 * k)); end
      n_vec++; if (out_inst !== exp_inst()) begin n_err++; $display("FAIL stream_inst[%0d] got=%h exp=%h", k, out_inst, exp_inst()); end
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count_o); end
      $display("stream: cycle=%0d head=%h count=%0d", k, out_addr, count_o);
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_tail_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_jump();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_addr = 32'h0000_2000 + 32'(4 * i); in_inst = $urandom;
      tick();
    end
    in_addr = 32'h0000_1234; jump_flag_i = 1; in_inst = $urandom;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL jump_in_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0; jump_flag_i = 0;
    n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL jump_count got=%0d exp=2", count_o); end
    $display("jump: squashed addr=00001234 count=%0d", count_o);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (out_valid && out_addr === 32'h0000_1234) begin n_err++; $display("FAIL jump_leak got=%h exp=not 00001234", out_addr); end
      n_vec++; if (out_addr !== exp_addr()) begin n_err++; $display("FAIL jump_drain[%0d] got=%h exp=%h", i, out_addr, exp_addr()); end
      $display("jump: drain head=%h valid=%0b", out_addr, out_valid);
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(3) != 0);
      out_ready   = ($urandom_range(2) != 0);
      flush_i     = ($urandom_range(15) == 0);
      jump_flag_i = ($urandom_range(7) == 0);
      in_addr     = $urandom;
      in_inst     = $urandom;
      n_vec++; if (in_ready !== (model.size() < DEPTH)) begin n_err++; $display("FAIL rand_in_ready[%0d] got=%0b exp=%0b", c, in_ready, model.size() < DEPTH); end
      tick();
      n_vec++; if (out_valid !== (model.size() != 0)) begin n_err++; $display("FAIL rand_out_valid[%0d] got=%0b exp=%0b", c, out_valid, model.size() != 0); end
      n_vec++; if (out_addr !== exp_addr()) begin n_err++; $display("FAIL rand_out_addr[%0d] got=%h exp=%h", c, out_addr, exp_addr()); end
      n_vec++; if (out_inst !== exp_inst()) begin n_err++; $display("FAIL rand_out_inst[%0d] got=%h exp=%h", c, out_inst, exp_inst()); end
      n_vec++; if (count_o !== 3'(model.size())) begin n_err++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, count_o, model.size()); end
      $display("rand: c=%0d v=%0b r=%0b fl=%0b j=%0b count=%0d head=%h", c, in_valid, out_ready, flush_i, jump_flag_i, count_o, out_addr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    out_ready = 1; flush_i = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_addr = 32'h0000_3000 + 32'(4 * i); in_inst = $urandom;
      tick();
    end
    in_valid = 0;
    n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL rstmid_pre_count got=%0d exp=3", count_o); end
    @(negedge clk);
    rst_n = 0;
    #1;
    model.delete();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_async_valid got=%0b exp=0", out_valid); end
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rstmid_async_count got=%0d exp=0", count_o); end
    n_vec++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_async_addr got=%h exp=0", out_addr); end
    @(negedge clk);
    rst_n = 1;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_post_valid got=%0b exp=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_post_ready got=%0b exp=1", in_ready); end
    $display("reset_mid: out_valid=%0b count=%0d", out_valid, count_o);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush_full();
    test_streaming();
    test_jump();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
